otter_hazard_ctrl: RTL and testbench



---
 rtl/otter_hazard_pkg.sv | 26 ++
 rtl/otter_sat_counter.sv | 22 ++
 rtl/otter_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_otter_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/otter_hazard_pkg.sv
// Shared types and helpers for the OTTER hazard / forwarding controller.
package otter_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR
  } dmem_state_t;

  function automatic logic writer_match(
    input logic       valid,
    input logic       reg_write,
    input logic [4:0] rd,
    input logic [4:0] src,
    input logic       used
  );
    return valid && reg_write && (rd != 5'd0) && (rd == src) && used;
  endfunction

endpackage

// File: rtl/otter_sat_counter.sv
// Saturating up-counter clocked on the pipeline's falling edge.
module otter_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/otter_hazard_ctrl.sv
// Hazard, forwarding, stall and DMEM-wait controller for the five-stage OTTER pipeline.
module otter_hazard_ctrl
  import otter_hazard_pkg::*;
#(
  parameter bit          FWD_EN  = 1'b1,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             DE_VALID,
  input  logic             DE_RS1_USED,
  input  logic             DE_RS2_USED,
  input  logic [4:0]       DE_RS1_ADDR,
  input  logic [4:0]       DE_RS2_ADDR,
  input  logic             EX_VALID,
  input  logic             EX_REG_WRITE,
  input  logic             EX_IS_LOAD,
  input  logic [4:0]       EX_RD_ADDR,
  input  logic             EX_BR_TAKEN,
  input  logic             MEM_VALID,
  input  logic             MEM_REG_WRITE,
  input  logic [4:0]       MEM_RD_ADDR,
  input  logic             DMEM_REQ,
  input  logic             DMEM_ACK,
  output logic             PC_HOLD,
  output logic             EX_BUBBLE,
  output logic             FLUSH_IF,
  output logic             FLUSH_DE,
  output logic             PIPE_HOLD,
  output logic [1:0]       FWD_A_SEL,
  output logic [1:0]       FWD_B_SEL,
  output logic             MEM_ERR,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  logic        rst_meta, rst_sync_n;
  logic        ex_m1, ex_m2, mem_m1, mem_m2;
  logic        stall, flush, bubble, pc_hold, dmem_hold;
  fwd_sel_t    fa_q, fb_q, fa_nx, fb_nx;
  dmem_state_t state, state_nx;
  logic [31:0] wait_cnt, wait_cnt_nx;
  logic        mem_err_q;

  // Asynchronous assert, release aligned to the falling edge used by all state here.
  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) {rst_meta, rst_sync_n} <= '0;
    else        {rst_meta, rst_sync_n} <= {1'b1, rst_meta};
  end

  always_comb begin
    ex_m1  = writer_match(EX_VALID, EX_REG_WRITE, EX_RD_ADDR, DE_RS1_ADDR, DE_VALID && DE_RS1_USED);
    ex_m2  = writer_match(EX_VALID, EX_REG_WRITE, EX_RD_ADDR, DE_RS2_ADDR, DE_VALID && DE_RS2_USED);
    mem_m1 = writer_match(MEM_VALID, MEM_REG_WRITE, MEM_RD_ADDR, DE_RS1_ADDR, DE_VALID && DE_RS1_USED);
    mem_m2 = writer_match(MEM_VALID, MEM_REG_WRITE, MEM_RD_ADDR, DE_RS2_ADDR, DE_VALID && DE_RS2_USED);
  end

  // Hold beats branch flush, which beats load-use / RAW stall.
  always_comb begin
    if (FWD_EN) stall = (ex_m1 || ex_m2) && EX_IS_LOAD;
    else        stall = ex_m1 || ex_m2 || mem_m1 || mem_m2;
    flush   = EX_BR_TAKEN && !dmem_hold;
    bubble  = stall && !dmem_hold && !flush;
    pc_hold = dmem_hold || (stall && !flush);
  end

  always_comb begin
    fa_nx = FWD_RF;
    fb_nx = FWD_RF;
    if (FWD_EN) begin
      if (ex_m1)       fa_nx = FWD_MEM;
      else if (mem_m1) fa_nx = FWD_WB;
      if (ex_m2)       fb_nx = FWD_MEM;
      else if (mem_m2) fb_nx = FWD_WB;
    end
  end

  always_ff @(negedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      fa_q <= FWD_RF;
      fb_q <= FWD_RF;
    end else if (!dmem_hold) begin
      fa_q <= (bubble || flush) ? FWD_RF : fa_nx;
      fb_q <= (bubble || flush) ? FWD_RF : fb_nx;
    end
  end

  // DMEM wait FSM: state register.
  always_ff @(negedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_cnt_nx;
      mem_err_q <= mem_err_q || (state_nx == ERR);
    end
  end

  // wait_cnt counts hold cycles already spent, so the cycle reaching TIMEOUT is the last held one.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    case (state)
      IDLE, WAIT: begin
        if (dmem_hold) begin
          wait_cnt_nx = wait_cnt + 32'd1;
          if ((TIMEOUT != 0) && (wait_cnt_nx >= TIMEOUT)) begin
            state_nx    = ERR;
            wait_cnt_nx = '0;
          end else begin
            state_nx = WAIT;
          end
        end else begin
          state_nx    = IDLE;
          wait_cnt_nx = '0;
        end
      end
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    dmem_hold = (state != ERR) && MEM_VALID && DMEM_REQ && !DMEM_ACK;
  end

  assign PC_HOLD   = rst_sync_n && pc_hold;
  assign EX_BUBBLE = rst_sync_n && bubble;
  assign FLUSH_IF  = rst_sync_n && flush;
  assign FLUSH_DE  = rst_sync_n && flush;
  assign PIPE_HOLD = rst_sync_n && dmem_hold;
  assign FWD_A_SEL = fa_q;
  assign FWD_B_SEL = fb_q;
  assign MEM_ERR   = mem_err_q;

  otter_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (rst_sync_n),
    .clear (1'b0),
    .inc   (PC_HOLD),
    .count (STALL_CNT)
  );

  otter_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (rst_sync_n),
    .clear (1'b0),
    .inc   (FLUSH_IF),
    .count (FLUSH_CNT)
  );

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Scoreboard bench for otter_hazard_ctrl: forwarding DUT (u0) and stall-only DUT (u1) share stimulus.
module tb_otter_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       DE_VALID, DE_RS1_USED, DE_RS2_USED;
  logic [4:0] DE_RS1_ADDR, DE_RS2_ADDR;
  logic       EX_VALID, EX_REG_WRITE, EX_IS_LOAD, EX_BR_TAKEN;
  logic [4:0] EX_RD_ADDR;
  logic       MEM_VALID, MEM_REG_WRITE, DMEM_REQ, DMEM_ACK;
  logic [4:0] MEM_RD_ADDR;

  logic       ph0, bub0, fi0, fd0, pipe0, err0, ph1, bub1, fi1, fd1, pipe1, err1;
  logic [1:0] fa0, fb0, fa1, fb1;
  logic [3:0] sc0, fc0, sc1, fc1;

  always #5 CLK = ~CLK;

  otter_hazard_ctrl #(.FWD_EN(1'b1), .TIMEOUT(4), .CNT_W(4)) u0 (
    .CLK(CLK), .RST_N(RST_N), .DE_VALID(DE_VALID), .DE_RS1_USED(DE_RS1_USED),
    .DE_RS2_USED(DE_RS2_USED), .DE_RS1_ADDR(DE_RS1_ADDR), .DE_RS2_ADDR(DE_RS2_ADDR),
    .EX_VALID(EX_VALID), .EX_REG_WRITE(EX_REG_WRITE), .EX_IS_LOAD(EX_IS_LOAD),
    .EX_RD_ADDR(EX_RD_ADDR), .EX_BR_TAKEN(EX_BR_TAKEN), .MEM_VALID(MEM_VALID),
    .MEM_REG_WRITE(MEM_REG_WRITE), .MEM_RD_ADDR(MEM_RD_ADDR), .DMEM_REQ(DMEM_REQ),
    .DMEM_ACK(DMEM_ACK), .PC_HOLD(ph0), .EX_BUBBLE(bub0), .FLUSH_IF(fi0), .FLUSH_DE(fd0),
    .PIPE_HOLD(pipe0), .FWD_A_SEL(fa0), .FWD_B_SEL(fb0), .MEM_ERR(err0),
    .STALL_CNT(sc0), .FLUSH_CNT(fc0)
  );

  otter_hazard_ctrl #(.FWD_EN(1'b0), .TIMEOUT(4), .CNT_W(4)) u1 (
    .CLK(CLK), .RST_N(RST_N), .DE_VALID(DE_VALID), .DE_RS1_USED(DE_RS1_USED),
    .DE_RS2_USED(DE_RS2_USED), .DE_RS1_ADDR(DE_RS1_ADDR), .DE_RS2_ADDR(DE_RS2_ADDR),
    .EX_VALID(EX_VALID), .EX_REG_WRITE(EX_REG_WRITE), .EX_IS_LOAD(EX_IS_LOAD),
    .EX_RD_ADDR(EX_RD_ADDR), .EX_BR_TAKEN(EX_BR_TAKEN), .MEM_VALID(MEM_VALID),
    .MEM_REG_WRITE(MEM_REG_WRITE), .MEM_RD_ADDR(MEM_RD_ADDR), .DMEM_REQ(DMEM_REQ),
    .DMEM_ACK(DMEM_ACK), .PC_HOLD(ph1), .EX_BUBBLE(bub1), .FLUSH_IF(fi1), .FLUSH_DE(fd1),
    .PIPE_HOLD(pipe1), .FWD_A_SEL(fa1), .FWD_B_SEL(fb1), .MEM_ERR(err1),
    .STALL_CNT(sc1), .FLUSH_CNT(fc1)
  );

  // {PC_HOLD, EX_BUBBLE, FLUSH_IF, FLUSH_DE, PIPE_HOLD, MEM_ERR, FWD_A_SEL, FWD_B_SEL}
  logic [9:0] got0, got1;
  assign got0 = {ph0, bub0, fi0, fd0, pipe0, err0, fa0, fb0};
  assign got1 = {ph1, bub1, fi1, fd1, pipe1, err1, fa1, fb1};

  typedef struct {
    string      name;
    bit         dut;
    logic [9:0] exp;
    bit         cc;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  function automatic logic [9:0] ev(bit ph, bit bub, bit fl, bit pipe, bit err,
                                    logic [1:0] fa, logic [1:0] fb);
    return {ph, bub, fl, fl, pipe, err, fa, fb};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Inputs are already set for this cycle; record what the DUT must show, then advance.
  task automatic cyc(input string nm, input bit d, input logic [9:0] e,
                     input bit cc = 1'b0, input logic [3:0] sc = 4'd0, input logic [3:0] fc = 4'd0);
    exp_t r;
    r.name = nm; r.dut = d; r.exp = e; r.cc = cc; r.cnt = {sc, fc};
    sb.push_back(r);
    tick();
  endtask

  task automatic idle();
    DE_VALID = 0; DE_RS1_USED = 0; DE_RS2_USED = 0; DE_RS1_ADDR = 0; DE_RS2_ADDR = 0;
    EX_VALID = 0; EX_REG_WRITE = 0; EX_IS_LOAD = 0; EX_RD_ADDR = 0; EX_BR_TAKEN = 0;
    MEM_VALID = 0; MEM_REG_WRITE = 0; MEM_RD_ADDR = 0; DMEM_REQ = 0; DMEM_ACK = 0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    idle();
    repeat (3) tick();
  endtask

  // Monitor: samples mid-cycle, well clear of the falling active edge.
  initial begin : monitor
    exp_t       r;
    logic [9:0] g;
    logic [7:0] gc;
    forever begin
      @(posedge CLK);
      #2;
      if (sb.size() != 0) begin
        r  = sb.pop_front();
        g  = r.dut ? got1 : got0;
        gc = r.dut ? {sc1, fc1} : {sc0, fc0};
        checks++;
        if (g !== r.exp) begin
          fails++;
          $display("FAIL %s dut%0d outputs: got %b want %b", r.name, r.dut, g, r.exp);
        end
        if (r.cc) begin
          checks++;
          if (gc !== r.cnt) begin
            fails++;
            $display("FAIL %s dut%0d counters {stall,flush}: got %h want %h", r.name, r.dut, gc, r.cnt);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    idle();
    tick();

    // Reset with a pending DMEM hold and a load-use hazard on the inputs: everything reads 0.
    RST_N = 1'b0;
    MEM_VALID = 1; DMEM_REQ = 1; EX_VALID = 1; EX_REG_WRITE = 1; EX_IS_LOAD = 1; EX_RD_ADDR = 5;
    DE_VALID = 1; DE_RS1_USED = 1; DE_RS1_ADDR = 5; EX_BR_TAKEN = 1;
    cyc("reset_u0", 0, ev(0,0,0,0,0,0,0), 1, 0, 0);
    cyc("reset_u1", 1, ev(0,0,0,0,0,0,0), 1, 0, 0);
    do_reset();

    // Load-use: lw x5 in EX, add x6,x5,x1 in DE.
    EX_VALID = 1; EX_REG_WRITE = 1; EX_IS_LOAD = 1; EX_RD_ADDR = 5;
    DE_VALID = 1; DE_RS1_USED = 1; DE_RS1_ADDR = 5; DE_RS2_USED = 1; DE_RS2_ADDR = 1;
    cyc("lu_stall", 0, ev(1,1,0,0,0,0,0), 1, 0, 0);
    EX_VALID = 0; EX_REG_WRITE = 0; EX_IS_LOAD = 0; EX_RD_ADDR = 0;
    MEM_VALID = 1; MEM_REG_WRITE = 1; MEM_RD_ADDR = 5; DMEM_REQ = 1; DMEM_ACK = 1;
    cyc("lu_release", 0, ev(0,0,0,0,0,0,0), 1, 1, 0);
    idle();
    cyc("lu_fwd", 0, ev(0,0,0,0,0,2'd2,2'd0), 1, 1, 0);
    cyc("lu_clear", 0, ev(0,0,0,0,0,0,0));
    do_reset();

    // Forward priority: EX and MEM both write x7, DE reads x7 on rs2.
    EX_VALID = 1; EX_REG_WRITE = 1; EX_RD_ADDR = 7;
    MEM_VALID = 1; MEM_REG_WRITE = 1; MEM_RD_ADDR = 7;
    DE_VALID = 1; DE_RS1_USED = 1; DE_RS1_ADDR = 2; DE_RS2_USED = 1; DE_RS2_ADDR = 7;
    cyc("prio_issue", 0, ev(0,0,0,0,0,0,0));
    EX_RD_ADDR = 0; MEM_RD_ADDR = 0; DE_RS1_ADDR = 0; DE_RS2_ADDR = 0;
    cyc("prio_ex_wins", 0, ev(0,0,0,0,0,2'd0,2'd1));
    EX_VALID = 0; EX_REG_WRITE = 0; MEM_RD_ADDR = 9; DE_RS1_ADDR = 9; DE_RS2_ADDR = 9;
    DE_RS2_USED = 0;
    cyc("x0_no_fwd", 0, ev(0,0,0,0,0,0,0));
    idle();
    cyc("mem_fwd_rs1_only", 0, ev(0,0,0,0,0,2'd2,2'd0));
    do_reset();

    // Stall-only mode on u1: MEM writer x3, then EX writer x4 followed by MEM writer x4.
    MEM_VALID = 1; MEM_REG_WRITE = 1; MEM_RD_ADDR = 3;
    DE_VALID = 1; DE_RS1_USED = 1; DE_RS1_ADDR = 3;
    cyc("raw_mem", 1, ev(1,1,0,0,0,0,0), 1, 0, 0);
    MEM_VALID = 0; MEM_REG_WRITE = 0; MEM_RD_ADDR = 0;
    cyc("raw_release", 1, ev(0,0,0,0,0,0,0), 1, 1, 0);
    DE_RS1_USED = 0; DE_RS1_ADDR = 0; DE_RS2_USED = 1; DE_RS2_ADDR = 4;
    EX_VALID = 1; EX_REG_WRITE = 1; EX_RD_ADDR = 4;
    cyc("raw_ex", 1, ev(1,1,0,0,0,0,0));
    EX_VALID = 0; EX_REG_WRITE = 0; EX_RD_ADDR = 0;
    MEM_VALID = 1; MEM_REG_WRITE = 1; MEM_RD_ADDR = 4;
    cyc("raw_ex_then_mem", 1, ev(1,1,0,0,0,0,0), 1, 2, 0);
    idle();
    cyc("raw_done", 1, ev(0,0,0,0,0,0,0), 1, 3, 0);
    do_reset();

    // Taken branch while the MEM access waits 3 cycles for ACK.
    EX_BR_TAKEN = 1; MEM_VALID = 1; DMEM_REQ = 1;
    for (int unsigned i = 0; i < 3; i++) cyc("br_hold", 0, ev(1,0,0,1,0,0,0));
    DMEM_ACK = 1;
    cyc("br_flush", 0, ev(0,0,1,0,0,0,0), 1, 3, 0);
    idle();
    cyc("br_after", 0, ev(0,0,0,0,0,0,0), 1, 3, 1);
    do_reset();

    // Timeout after 4 held cycles, sticky MEM_ERR, then reset mid-WAIT.
    MEM_VALID = 1; DMEM_REQ = 1;
    for (int unsigned i = 0; i < 4; i++) cyc("to_hold", 0, ev(1,0,0,1,0,0,0));
    cyc("to_err", 0, ev(0,0,0,0,1,0,0), 1, 4, 0);
    idle();
    cyc("to_sticky", 0, ev(0,0,0,0,1,0,0), 1, 4, 0);
    MEM_VALID = 1; DMEM_REQ = 1; DMEM_ACK = 1;
    cyc("ack_same_cycle", 0, ev(0,0,0,0,1,0,0));
    DMEM_ACK = 0;
    cyc("wait2_hold", 0, ev(1,0,0,1,1,0,0));
    cyc("wait2_hold", 0, ev(1,0,0,1,1,0,0), 1, 5, 0);
    RST_N = 1'b0;
    cyc("rst_mid_wait_u0", 0, ev(0,0,0,0,0,0,0), 1, 0, 0);
    cyc("rst_mid_wait_u1", 1, ev(0,0,0,0,0,0,0), 1, 0, 0);
    do_reset();

    // Continuous stall saturates the 4-bit counter at 15.
    EX_VALID = 1; EX_REG_WRITE = 1; EX_IS_LOAD = 1; EX_RD_ADDR = 12;
    DE_VALID = 1; DE_RS2_USED = 1; DE_RS2_ADDR = 12;
    for (int unsigned i = 0; i < 18; i++)
      cyc("sat", 0, ev(1,1,0,0,0,0,0), 1, (i > 15) ? 4'd15 : 4'(i), 0);
    idle();

    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
